// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, segment table and FSM state type for seg_scan_ctrl
package seg_scan_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Segment order a..g maps to bit 6..0; entries 10-15 are hex glyphs the controller blanks.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic logic [6:0] seg_lut(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/bcd_7_seg.sv
// rtl/bcd_7_seg.sv - combinational BCD/hex nibble to 7-segment pattern decoder
module bcd_7_seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_lut(bcd);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [15:0] DIV        = 16'd50000,
    parameter logic [15:0] BLANK_CYC  = 16'd1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int              DW         = $clog2(NUM_DIGITS);
    localparam int              VW         = 4 * NUM_DIGITS;
    localparam logic [DW-1:0]   LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [15:0]     SHOW_LAST  = DIV - BLANK_CYC - 16'd1;
    localparam logic [15:0]     GAP_LAST   = BLANK_CYC - 16'd1;

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic                    fd_q, fd_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [VW-1:0]           shadow_q, shadow_d;
    logic [VW-1:0]           active_q, active_d;
    logic                    pending_q, pending_d;
    logic                    copy;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic                    lit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        fd_d    = 1'b0;
        copy    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = 16'd0;
                    digit_d = '0;
                    copy    = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = GAP;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = SHOW;
                        cnt_d   = 16'd0;
                        if (digit_q == LAST_DIGIT) begin
                            digit_d = '0;
                            fd_d    = 1'b1;
                            copy    = 1'b1;
                        end else begin
                            digit_d = digit_q + DW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // A load coinciding with the frame-boundary copy lands in shadow and stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (copy && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib = active_d[4*int'(digit_d) +: 4];
    end

    bcd_7_seg u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic higher_nz;

    always_comb begin
        higher_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k > int'(digit_d) && active_d[4*k +: 4] != 4'd0) begin
                higher_nz = 1'b1;
            end
        end
        lit = (cur_nib <= 4'd9) && (cur_nib != 4'd0 || digit_d == '0 || higher_nz);
    end
`else
    always_comb begin
        lit = (cur_nib <= 4'd9);
    end
`endif

    // Outputs are computed from next-state values so they change on the transition edge.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == SHOW) begin
            an_d[digit_d] = 1'b0;
            if (lit) begin
                seg_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            digit_q   <= '0;
            fd_q      <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            fd_q      <= fd_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = digit_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (DIV=8, BLANK_CYC=2, 4 digits)
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .DIV        (16'd8),
        .BLANK_CYC  (16'd2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
`ifdef SEG_SCAN_LZB_EN
        begin
            logic [15:0] hi;
            hi = (d == 3) ? 16'h0000 : (v >> (4 * (d + 1)));
            if (nib == 4'd0 && d != 0 && hi == 16'h0000) return 7'b0000000;
        end
`endif
        case (nib)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        step();
        step();
        vectors++;
        if ({an, seg, digit_idx, frame_done} !== {4'b1111, 7'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: an=%b seg=%b idx=%0d fd=%b, expected an=1111 seg=0000000 idx=0 fd=0",
                     an, seg, digit_idx, frame_done);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({an, seg, digit_idx, frame_done} !== {4'b1111, 7'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_disabled: an=%b seg=%b idx=%0d fd=%b, expected an=1111 seg=0000000 idx=0 fd=0",
                     an, seg, digit_idx, frame_done);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        logic [6:0] es;
        int d, i;
        value = 16'h1234;
        load = 1'b1;
        step();
        load = 1'b0;
        enable = 1'b1;
        step();
        for (int c = 0; c < 64; c++) begin
            d = (c / 8) % 4;
            i = c % 8;
            ea = 4'hF;
            es = 7'b0;
            if (i < 6) begin
                ea[d] = 1'b0;
                es = ref_seg(16'h1234, d);
            end
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {ea, es, d[1:0], (c == 32)}) begin
                miscompares++;
                $display("FAIL scan c=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=%b seg=%b idx=%0d fd=%b",
                         c, an, seg, digit_idx, frame_done, ea, es, d, (c == 32));
            end
            step();
        end
    endtask

    task automatic test_reload(input string tag, input logic [15:0] old_v,
                               input logic [15:0] new_v, input int load_c);
        logic [3:0]  ea;
        logic [6:0]  es;
        logic [15:0] v;
        int d, i;
        for (int c = 0; c < 64; c++) begin
            d = (c / 8) % 4;
            i = c % 8;
            v = (c < 32) ? old_v : new_v;
            ea = 4'hF;
            es = 7'b0;
            if (i < 6) begin
                ea[d] = 1'b0;
                es = ref_seg(v, d);
            end
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {ea, es, d[1:0], (c % 32 == 0)}) begin
                miscompares++;
                $display("FAIL %s c=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=%b seg=%b idx=%0d fd=%b",
                         tag, c, an, seg, digit_idx, frame_done, ea, es, d, (c % 32 == 0));
            end
            if (c == load_c) begin
                value = new_v;
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end
    endtask

    task automatic test_load_at_copy();
        logic [3:0]  ea;
        logic [6:0]  es;
        logic [15:0] v;
        int d, i;
        for (int c = 0; c < 96; c++) begin
            d = (c / 8) % 4;
            i = c % 8;
            v = (c < 32) ? 16'h0050 : (c < 64) ? 16'h0007 : 16'h0008;
            ea = 4'hF;
            es = 7'b0;
            if (i < 6) begin
                ea[d] = 1'b0;
                es = ref_seg(v, d);
            end
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {ea, es, d[1:0], (c % 32 == 0)}) begin
                miscompares++;
                $display("FAIL load_at_copy c=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=%b seg=%b idx=%0d fd=%b",
                         c, an, seg, digit_idx, frame_done, ea, es, d, (c % 32 == 0));
            end
            if (c == 0) begin
                value = 16'h0007;
                load = 1'b1;
            end else if (c == 31) begin
                value = 16'h0008;
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end
    endtask

    task automatic test_disable();
        logic [3:0] ea;
        logic [6:0] es;
        int d, i;
        for (int c = 0; c < 15; c++) begin
            d = c / 8;
            i = c % 8;
            ea = 4'hF;
            es = 7'b0;
            if (i < 6) begin
                ea[d] = 1'b0;
                es = ref_seg(16'h0008, d);
            end
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {ea, es, d[1:0], (c == 0)}) begin
                miscompares++;
                $display("FAIL pre_disable c=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=%b seg=%b idx=%0d fd=%b",
                         c, an, seg, digit_idx, frame_done, ea, es, d, (c == 0));
            end
            if (c < 14) step();
        end
        enable = 1'b0;
        step();
        for (int k = 0; k < 40; k++) begin
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {4'b1111, 7'b0, 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL disabled k=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=1111 seg=0000000 idx=0 fd=0",
                         k, an, seg, digit_idx, frame_done);
            end
            step();
        end
        enable = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            d = c / 8;
            i = c % 8;
            ea = 4'hF;
            es = 7'b0;
            if (i < 6) begin
                ea[d] = 1'b0;
                es = ref_seg(16'h0008, d);
            end
            vectors++;
            if ({an, seg, digit_idx, frame_done} !== {ea, es, d[1:0], 1'b0}) begin
                miscompares++;
                $display("FAIL reenable c=%0d: an=%b seg=%b idx=%0d fd=%b, expected an=%b seg=%b idx=%0d fd=0",
                         c, an, seg, digit_idx, frame_done, ea, es, d);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        vectors++;
        if ({an, digit_idx} !== {4'b1011, 2'd2}) begin
            miscompares++;
            $display("FAIL pre_reset: an=%b idx=%0d, expected an=1011 idx=2", an, digit_idx);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({an, seg, digit_idx, frame_done} !== {4'b1111, 7'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: an=%b seg=%b idx=%0d fd=%b, expected an=1111 seg=0000000 idx=0 fd=0",
                     an, seg, digit_idx, frame_done);
        end
        #2;
        rst = 1'b0;
        step();
        vectors++;
        if ({an, seg, digit_idx, frame_done} !== {4'b1110, 7'b1111110, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset_show: an=%b seg=%b idx=%0d fd=%b, expected an=1110 seg=1111110 idx=0 fd=0",
                     an, seg, digit_idx, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_reload("tear_free", 16'h1234, 16'h5678, 18);
        test_reload("invalid", 16'h5678, 16'hF909, 0);
        test_reload("lzb", 16'hF909, 16'h0050, 0);
        test_load_at_copy();
        test_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds one BCD nibble per digit and walks a single shared BCD-to-7-segment decoder across the digits.
- Drives one active-low anode enable per digit, with a blanking gap between digits to prevent ghosting.
- Sits between the numeric datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- DIV, 16'd50000: clock cycles per digit slot, SHOW plus GAP.
- BLANK_CYC, 16'd1000: cycles of each slot spent in GAP with all anodes off; must satisfy 1 ≤ BLANK_CYC < DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scanning enabled; low forces the display dark
- load  in  1  one-cycle strobe that captures value
- value  in  4*NUM_DIGITS  BCD digits; digit 0 = value[3:0] = rightmost
- seg  out  7  segments a..g = seg[6:0], active-high (1 = lit)
- an  out  NUM_DIGITS  anode enables, active-low
- digit_idx  out  $clog2(NUM_DIGITS)  digit currently in its slot
- frame_done  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Reset (async, rst=1): state=IDLE, an=all ones, seg=0, digit_idx=0, frame_done=0, slot counter=0, shadow=0, active=0, pending=0.
- Registers:
  - shadow: captures value on load=1.
  - active: the register actually displayed.
  - pending: set by load, cleared when shadow is copied to active.
- Tear-free update: shadow→active copy occurs only at a frame boundary, i.e. on the edge where the GAP of digit NUM_DIGITS-1 ends, or on the IDLE→SHOW transition. A load in the same cycle as the copy wins: the new value is captured into shadow and pending stays 1.
- States:
  - IDLE: an all ones, seg=0. Leaves to SHOW (digit 0, counter=0) when enable=1.
  - SHOW: an[digit_idx]=0 and all other anode bits are 1. seg = decode(active digit). Lasts DIV-BLANK_CYC cycles, then → GAP.
  - GAP: an all ones, seg=0. Lasts BLANK_CYC cycles, then → SHOW with digit_idx+1, wrapping NUM_DIGITS-1→0.
- frame_done pulses high for exactly one cycle on the edge when digit_idx wraps to 0.
- enable=0 in any state: → IDLE on the next edge. digit_idx and the counter clear; an/seg go dark on that edge. A mid-frame disable never produces a frame_done pulse.
- Output registers: an, seg and digit_idx are registered and updated on the same edge as the state transition. There is no combinational path from inputs to outputs.
- Decoding: BCD 0–9 uses standard patterns, 0→7'b1111110 through 9→7'b1111011.
- Invalid codes: nibbles 10–15 are forced to seg=0 (blank) regardless of decoder output.
- Counter width is 16 bits. Terminal count compares against DIV-BLANK_CYC-1 in SHOW and BLANK_CYC-1 in GAP.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN, leading-zero blanking.
- Defined: a digit is lit only if it is nonzero, or it is digit 0, or some higher-index digit is nonzero. Digits that fail this test show seg=0 during SHOW, with the anode still driven, so timing is unchanged.
- Undefined: all digits are always displayed.

Decomposition:
- Package seg_scan_pkg:
  - SEG_OFF = 7'b0000000
  - the 16-entry segment lookup constant
  - state enum typedef {IDLE, SHOW, GAP}
  - function seg_lut(nibble)
- Sub-module: the existing bcd_7_seg decoder, instantiated once and fed by the digit mux. Its invalid-code output is overridden by the controller's blanking rule.

Test Plan (DIV=8, BLANK_CYC=2, NUM_DIGITS=4):
- Reset:
  - Stimulus: assert rst mid-SHOW, asynchronously.
  - Required: an=4'b1111, seg=0 and digit_idx=0 immediately, without waiting for a clock edge. After release with enable=1, the first SHOW of digit 0 follows on the next edge.
- Scan timing:
  - Stimulus: load value=16'h1234, then enable=1.
  - Required, per slot: an=1110 for 6 cycles with seg=4 (7'b0110011), then an=1111 for 2 cycles.
  - Digits 1, 2, 3 follow in order.
  - frame_done pulses once every 32 cycles.
- Tear-free load:
  - Stimulus: load 16'h5678 while digit 2 is in SHOW.
  - Required: digit 3 still shows 1. The new digits appear starting at the next frame's digit 0.
- Invalid/boundary codes:
  - Stimulus: value=16'hF909.
  - Required: digit 3 seg=0. Digit 2 shows 9. Digit 1 shows 0 (1111110), or blank with SEG_SCAN_LZB_EN defined, because no higher-index digit is nonzero only if digit 2 were 0 — here digit 2 is 9, so digit 1 shows 1111110 in both builds. Digit 0 shows 9.
- Leading-zero blanking (LZB build):
  - Stimulus: value=16'h0050.
  - Required: digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0.
- Disable mid-frame:
  - Stimulus: drop enable during digit 1 GAP.
  - Required: next edge an=1111, no frame_done pulse. Re-enable → scanning restarts at digit 0.
